// File: rtl/regfile_write_ctrl.sv
// Write-side controller for the integer register file: ALU/LSU write-back arbitration,
// long-latency destination scoreboard, and in-flight write forwarding for decode.
module regfile_write_ctrl #(
  parameter int unsigned width_p = 32,
  parameter int unsigned depth_p = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    alu_valid_i,
  input  logic [((depth_p > 1) ? $clog2(depth_p) : 1)-1:0] alu_rd_i,
  input  logic [width_p-1:0]                      alu_data_i,
  input  logic                                    lsu_valid_i,
  output logic                                    lsu_ready_o,
  input  logic [((depth_p > 1) ? $clog2(depth_p) : 1)-1:0] lsu_rd_i,
  input  logic [width_p-1:0]                      lsu_data_i,
  input  logic                                    issue_valid_i,
  input  logic [((depth_p > 1) ? $clog2(depth_p) : 1)-1:0] issue_rd_i,
  input  logic [((depth_p > 1) ? $clog2(depth_p) : 1)-1:0] rs1_addr_i,
  input  logic [((depth_p > 1) ? $clog2(depth_p) : 1)-1:0] rs2_addr_i,
  output logic                                    rs1_busy_o,
  output logic                                    rs2_busy_o,
  output logic                                    rs1_fwd_valid_o,
  output logic [width_p-1:0]                      rs1_fwd_data_o,
  output logic                                    rs2_fwd_valid_o,
  output logic [width_p-1:0]                      rs2_fwd_data_o,
  output logic                                    wr_en_o,
  output logic [((depth_p > 1) ? $clog2(depth_p) : 1)-1:0] rd_addr_o,
  output logic [width_p-1:0]                      rd_data_o,
  output logic                                    sb_err_o
);

  localparam int unsigned AW   = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int unsigned NREG = 1 << AW;

  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic [width_p-1:0] rd_data_q, rd_data_d;
  logic [NREG-1:0]    pending_q, pending_d;
  logic               sb_err_q, sb_err_d;

  logic               lsu_hs;
  logic               sel_valid;
  logic [AW-1:0]      sel_rd;
  logic [width_p-1:0] sel_data;
  logic [NREG-1:0]    set_vec, clr_vec;
  logic               err_issue, err_lsu;

  // ALU always wins; the LSU is only offered the port when the ALU is idle.
  assign lsu_ready_o = ~rst_i & ~alu_valid_i;
  assign lsu_hs      = lsu_valid_i & lsu_ready_o;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid_i) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd_i;
      sel_data  = alu_data_i;
    end else if (lsu_hs) begin
      sel_valid = 1'b1;
      sel_rd    = lsu_rd_i;
      sel_data  = lsu_data_i;
    end
  end

  // x0 writes are consumed but never reach the port; address/data hold when idle.
  always_comb begin
    wr_en_d   = sel_valid & (sel_rd != '0);
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (wr_en_d) begin
      rd_addr_d = sel_rd;
      rd_data_d = sel_data;
    end
  end

  // Scoreboard: a new issue overrides a completion to the same register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid_i && (issue_rd_i != '0) && (32'(issue_rd_i) < depth_p)) begin
      set_vec[issue_rd_i] = 1'b1;
    end
    if (lsu_hs && (lsu_rd_i != '0)) begin
      clr_vec[lsu_rd_i] = 1'b1;
    end
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    err_issue = issue_valid_i & (issue_rd_i != '0) & pending_q[issue_rd_i]
              & ~clr_vec[issue_rd_i];
    err_lsu   = lsu_hs & (lsu_rd_i != '0) & ~pending_q[lsu_rd_i];
    sb_err_d  = sb_err_q | err_issue | err_lsu;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  // Busy comes from registered scoreboard state only; pending_q[0] is never set.
  assign rs1_busy_o      = pending_q[rs1_addr_i];
  assign rs2_busy_o      = pending_q[rs2_addr_i];
  assign rs1_fwd_valid_o = wr_en_q & (rd_addr_q == rs1_addr_i);
  assign rs2_fwd_valid_o = wr_en_q & (rd_addr_q == rs2_addr_i);
  assign rs1_fwd_data_o  = rd_data_q;
  assign rs2_fwd_data_o  = rd_data_q;

  assign wr_en_o   = wr_en_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign sb_err_o  = sb_err_q;

endmodule
